mult_batch_arbiter: RTL and testbench
=====================================

# mult_batch_arbiter

Round-robin batch scheduler that shares one `multiplier` instance and its 2^LOGDEPTH-entry result memory between NREQ requesters. A granted requester owns the multiplier for one full batch: a fill of exactly 2^LOGDEPTH operand pairs, then a block read of all 2^LOGDEPTH products back to that requester. Sits between the requester fabric and the multiplier's `EN_mult`/`RDY_mult` and `EN_blockRead`/`VALID_memVal` ports.

## Interface
- `NREQ`, 2: number of requesters (2..8).
- `LOGDEPTH`, 6: log2 batch size; must match the multiplier.
- `WIDTH`, 32: product width.
- `TIMEOUT`, 256: idle-cycle limit in WAIT_FULL/DRAIN before abort.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  requester i has an operand pair on its slice.
- `req_op0`, `req_op1`  in  NREQ*16  packed operands; requester i at [16i+15:16i].
- `req_ready`  out  NREQ  operand pair of requester i accepted this cycle when high with `req_valid[i]`.
- `res_valid`  out  NREQ  product valid for requester i.
- `res_data`  out  WIDTH  product (shared by all requesters).
- `grant_id`  out  $clog2(NREQ)  current owner; meaningful when `busy`.
- `busy`  out  1  high in any state but IDLE.
- `err`  out  1  sticky timeout flag; cleared only by `rst`.
- `EN_mult`  out  1  to multiplier.
- `mult_input0`, `mult_input1`  out  16  to multiplier.
- `RDY_mult`  in  1  from multiplier.
- `EN_blockRead`  out  1  to multiplier.
- `VALID_memVal`  in  1  from multiplier.
- `memVal_data`  in  WIDTH  from multiplier.

## Operation
- States: IDLE, FILL, WAIT_FULL, DRAIN_REQ, DRAIN.
- IDLE: if any `req_valid`, pick first set bit scanning from `last_grant+1` upward mod NREQ; register `grant_id`, clear `op_cnt`/`res_cnt`, go FILL. No grant -> stay.
- FILL: `req_ready[g] = RDY_mult`, other `req_ready` 0; `EN_mult = req_valid[g] & RDY_mult`; `mult_input0/1` = slice g of `req_op0/1` (combinational mux). Each accept increments `op_cnt` (LOGDEPTH+1 bits). On the accept that makes `op_cnt == 2^LOGDEPTH`, go WAIT_FULL. Requester deasserting `req_valid` stalls FILL indefinitely; grant held, no timeout.
- WAIT_FULL: `EN_mult` 0, all `req_ready` 0. On `RDY_mult == 0`, go DRAIN_REQ.
- DRAIN_REQ: `EN_blockRead = 1` for exactly this one cycle; go DRAIN.
- DRAIN: `res_valid[g] = VALID_memVal`, others 0; `res_data = memVal_data` (always passed through). Each `VALID_memVal` increments `res_cnt`; on the pulse making `res_cnt == 2^LOGDEPTH`, set `last_grant = g`, go IDLE.
- Watchdog: in WAIT_FULL and DRAIN a counter counts cycles without progress (RDY_mult low / VALID_memVal); resets on progress and on state entry. Reaching TIMEOUT: set `err`, set `last_grant = g`, go IDLE.
- `VALID_memVal` outside DRAIN is ignored; never forwarded.
- Requests from non-owners are held off (`req_ready` 0) until the batch ends; no preemption.

## Timing
- Reset values: state IDLE, `last_grant = NREQ-1` (requester 0 wins first), `grant_id` 0, counters 0, `err` 0; all outputs 0 while `rst` high and in IDLE.
- Reset mid-batch: next cycle IDLE, all outputs 0; multiplier must be reset concurrently (same `rst`).
- Grant latency: `req_valid` seen in IDLE at cycle n -> FILL with `req_ready` possible at n+1.
- FILL throughput: one pair/cycle while `req_valid[g] & RDY_mult`.
- `EN_blockRead` issued 1 cycle after `RDY_mult` low is observed in WAIT_FULL.
- Return to IDLE 1 cycle after final result; new grant can be taken the following cycle (min 1 IDLE cycle between batches).
- `req_ready`, `EN_mult`, `res_valid`, `res_data`, operand mux: combinational from registered state and inputs; no extra latency.

## Test plan
- Single requester, NREQ=2, LOGDEPTH=6: req 0 streams 64 pairs (a=i, b=3) -> 64 `EN_mult` pulses, one `EN_blockRead` pulse, 64 `res_valid[0]` with `res_data` = 3*i in order, `busy` falls after 64th.
- Contention: both `req_valid` high from reset -> grant 0 first batch, grant 1 second; third batch with both high -> grant 0; `req_ready[1]` stays 0 during batch 0.
- Stall in FILL: req 0 drops `req_valid` for 20 cycles after 10 pairs -> no `EN_mult`, `op_cnt` holds 10, completes normally after resume; no `err`.
- Timeout: model holds `RDY_mult` high after 64 accepts for 256 cycles -> `err` = 1, back to IDLE, no `EN_blockRead`; `err` stays 1 until `rst`.
- Reset mid-DRAIN after 30 results -> next cycle `busy` 0, `res_valid` 0, next grant goes to requester 0.
- Spurious `VALID_memVal` in IDLE/FILL -> no `res_valid` on any requester.

Source files
------------

// File: rtl/mult_batch_arbiter_if.sv
// Requester-fabric and multiplier-side signals of mult_batch_arbiter.
// master = arbiter side, slave = requesters plus multiplier.
interface mult_batch_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*16-1:0] req_op0;
    logic [NREQ*16-1:0] req_op1;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    res_valid;
    logic [WIDTH-1:0]   res_data;
    logic [GW-1:0]      grant_id;
    logic               busy;
    logic               err;
    logic               EN_mult;
    logic [15:0]        mult_input0;
    logic [15:0]        mult_input1;
    logic               RDY_mult;
    logic               EN_blockRead;
    logic               VALID_memVal;
    logic [WIDTH-1:0]   memVal_data;

    modport master (
        input  req_valid, req_op0, req_op1,
        input  RDY_mult, VALID_memVal, memVal_data,
        output req_ready, res_valid, res_data,
        output grant_id, busy, err,
        output EN_mult, mult_input0, mult_input1,
        output EN_blockRead
    );

    modport slave (
        output req_valid, req_op0, req_op1,
        output RDY_mult, VALID_memVal, memVal_data,
        input  req_ready, res_valid, res_data,
        input  grant_id, busy, err,
        input  EN_mult, mult_input0, mult_input1,
        input  EN_blockRead
    );
endinterface

// File: rtl/mult_batch_arbiter.sv
// Round-robin batch scheduler sharing one multiplier and its result
// memory: a grant covers one full fill plus one full block read.
module mult_batch_arbiter #(
    parameter int NREQ     = 2,
    parameter int LOGDEPTH = 6,
    parameter int WIDTH    = 32,
    parameter int TIMEOUT  = 256
) (
    input  logic clk,
    input  logic rst,
    mult_batch_arbiter_if.master bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = LOGDEPTH + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH     = CW'(2 ** LOGDEPTH);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);
    localparam logic [GW-1:0] LAST_INIT = GW'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WAIT_FULL,
        S_DRAIN_REQ,
        S_DRAIN
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [GW-1:0] r_grant, w_grant_nxt;
    logic [GW-1:0] r_last, w_last_nxt;
    logic [CW-1:0] r_op_cnt, w_op_nxt;
    logic [CW-1:0] r_res_cnt, w_res_nxt;
    logic [WW-1:0] r_wd, w_wd_nxt;
    logic          r_err, w_err_nxt;

    logic [GW-1:0]   w_pick;
    logic [GW-1:0]   w_idx;
    logic            w_any;
    logic            w_fill;
    logic            w_drain;
    logic            w_busy;
    logic            w_gvalid;
    logic            w_accept;
    logic [15:0]     w_op0;
    logic [15:0]     w_op1;
    logic [NREQ-1:0] w_ready;
    logic [NREQ-1:0] w_resv;
    logic [CW-1:0]   w_op_inc;
    logic [CW-1:0]   w_res_inc;

    // Outputs are forced quiet while rst is high.
    assign w_fill  = ~rst & (r_state == S_FILL);
    assign w_drain = ~rst & (r_state == S_DRAIN);
    assign w_busy  = ~rst & (r_state != S_IDLE);

    assign w_accept  = (r_state == S_FILL) & w_gvalid & bus.RDY_mult;
    assign w_op_inc  = r_op_cnt + CW'(1);
    assign w_res_inc = r_res_cnt + CW'(1);

    // Round-robin pick: first requester after last_grant, wrapping.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        w_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = GW'((int'(r_last) + k) % NREQ);
            if (!w_any && bus.req_valid[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    // Owner slice select and per-requester handshake decode.
    always_comb begin
        w_gvalid = 1'b0;
        w_op0    = '0;
        w_op1    = '0;
        w_ready  = '0;
        w_resv   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant == GW'(i)) begin
                w_gvalid   = bus.req_valid[i];
                w_op0      = bus.req_op0[i*16 +: 16];
                w_op1      = bus.req_op1[i*16 +: 16];
                w_ready[i] = w_fill & bus.RDY_mult;
                w_resv[i]  = w_drain & bus.VALID_memVal;
            end
        end
    end

    // Next-state: batch sequencing, counters and watchdog.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_op_nxt    = r_op_cnt;
        w_res_nxt   = r_res_cnt;
        w_wd_nxt    = r_wd;
        w_err_nxt   = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant_nxt = w_pick;
                    w_op_nxt    = '0;
                    w_res_nxt   = '0;
                    w_wd_nxt    = '0;
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (w_accept) begin
                    w_op_nxt = w_op_inc;
                    if (w_op_inc == DEPTH) begin
                        w_wd_nxt    = '0;
                        w_state_nxt = S_WAIT_FULL;
                    end
                end
            end
            S_WAIT_FULL: begin
                if (!bus.RDY_mult) begin
                    w_wd_nxt    = '0;
                    w_state_nxt = S_DRAIN_REQ;
                end else if (r_wd == WD_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_last_nxt  = r_grant;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wd_nxt = r_wd + WW'(1);
                end
            end
            S_DRAIN_REQ: begin
                w_wd_nxt    = '0;
                w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.VALID_memVal) begin
                    w_res_nxt = w_res_inc;
                    w_wd_nxt  = '0;
                    if (w_res_inc == DEPTH) begin
                        w_last_nxt  = r_grant;
                        w_state_nxt = S_IDLE;
                    end
                end else if (r_wd == WD_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_last_nxt  = r_grant;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wd_nxt = r_wd + WW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; reset makes requester 0 win first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_last    <= LAST_INIT;
            r_op_cnt  <= '0;
            r_res_cnt <= '0;
            r_wd      <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_last    <= w_last_nxt;
            r_op_cnt  <= w_op_nxt;
            r_res_cnt <= w_res_nxt;
            r_wd      <= w_wd_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign bus.busy         = w_busy;
    assign bus.grant_id     = w_busy ? r_grant : '0;
    assign bus.err          = ~rst & r_err;
    assign bus.req_ready    = w_ready;
    assign bus.EN_mult      = w_fill & w_gvalid & bus.RDY_mult;
    assign bus.mult_input0  = w_fill ? w_op0 : 16'd0;
    assign bus.mult_input1  = w_fill ? w_op1 : 16'd0;
    assign bus.EN_blockRead = ~rst & (r_state == S_DRAIN_REQ);
    assign bus.res_valid    = w_resv;
    assign bus.res_data     = w_drain ? bus.memVal_data : '0;
endmodule

// File: tb/tb_mult_batch_arbiter.sv
// Bench for mult_batch_arbiter: requester streams, a behavioural
// multiplier with result memory, and directed batch sequences.
module tb_mult_batch_arbiter;
    localparam int NREQ     = 2;
    localparam int LOGDEPTH = 6;
    localparam int WIDTH    = 32;
    localparam int TIMEOUT  = 256;
    localparam int DEPTH    = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_batch_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    mult_batch_arbiter #(
        .NREQ(NREQ),
        .LOGDEPTH(LOGDEPTH),
        .WIDTH(WIDTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [NREQ-1:0] rv;
    logic            hold_rdy;
    logic            spur;

    assign bus.req_valid = rv;

    // Requester i sends a = k + 256*i, b = 3 + i for its k-th pair.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        logic [5:0] cnt;
        assign bus.req_op0[gi*16 +: 16] = {10'd0, cnt} + 16'(256 * gi);
        assign bus.req_op1[gi*16 +: 16] = 16'(3 + gi);
        always @(posedge clk) begin
            if (rst)
                cnt <= '0;
            else if (rv[gi] && bus.req_ready[gi])
                cnt <= cnt + 6'd1;
        end
    end

    // Behavioural multiplier: fill 64, drop RDY, block-read on request.
    logic        m_rdy;
    logic        m_drain;
    logic [6:0]  m_cnt;
    logic [5:0]  m_rd;
    logic [31:0] m_mem [DEPTH];

    assign bus.RDY_mult     = m_rdy;
    assign bus.VALID_memVal = m_drain | spur;
    assign bus.memVal_data  = m_drain ? m_mem[m_rd] : 32'hdead_beef;

    always @(posedge clk) begin
        if (rst) begin
            m_rdy   <= 1'b1;
            m_drain <= 1'b0;
            m_cnt   <= '0;
            m_rd    <= '0;
        end else begin
            if (bus.EN_mult && m_rdy) begin
                m_mem[m_cnt[5:0]] <= 32'(bus.mult_input0) * 32'(bus.mult_input1);
                m_cnt <= m_cnt + 7'd1;
                if (m_cnt == 7'd63 && !hold_rdy)
                    m_rdy <= 1'b0;
            end
            if (bus.EN_blockRead) begin
                m_drain <= 1'b1;
                m_rd    <= '0;
            end else if (m_drain) begin
                m_rd <= m_rd + 6'd1;
                if (m_rd == 6'd63) begin
                    m_drain <= 1'b0;
                    m_rdy   <= 1'b1;
                    m_cnt   <= '0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] exp_prod(input int g, input int j);
        return 32'((j + 256 * g) * (3 + g));
    endfunction

    // One batch: raise requests, observe at negedge, drive at posedge+1.
    task automatic run_batch(input logic [NREQ-1:0] v, input int g,
                             input int stall_at, input bit to_mode,
                             input int rst_at, input bit spur_mode);
        logic [NREQ-1:0] oh;
        int lat, en, br, res, viol, wait_n;
        int stall_cnt, stall_en;
        bit granted, done, stalling, stall_done;
        oh = NREQ'(1) << g;
        lat = 0; en = 0; br = 0; res = 0; viol = 0; wait_n = 0;
        stall_cnt = 0; stall_en = 0;
        granted = 0; done = 0; stalling = 0; stall_done = 0;
        @(posedge clk);
        #1;
        rv = v;
        hold_rdy = to_mode;
        spur = spur_mode;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!granted) begin
                lat++;
                if (lat == 1)
                    check("idle_res_valid", 64'(bus.res_valid), 64'd0);
                if (bus.busy) begin
                    granted = 1;
                    check("grant_latency", 64'(lat), 64'd2);
                    check("grant_id", 64'(bus.grant_id), 64'(g));
                end
            end else if (!bus.busy) begin
                done = 1;
            end
            if (bus.EN_mult) en++;
            if (stalling && bus.EN_mult) stall_en++;
            if (bus.EN_blockRead) br++;
            if (bus.busy && en >= DEPTH && !bus.EN_mult) wait_n++;
            if (bus.busy && (bus.req_ready & ~oh) != '0) viol++;
            if (bus.res_valid != '0) begin
                check("res_valid", 64'(bus.res_valid), 64'(oh));
                check("res_data", 64'(bus.res_data), 64'(exp_prod(g, res)));
                res++;
            end
            if (done) break;
            @(posedge clk);
            #1;
            if (en >= DEPTH) begin
                rv = '0;
                spur = 1'b0;
            end else if (stalling) begin
                stall_cnt++;
                if (stall_cnt == 20) begin
                    stalling = 0;
                    rv = v;
                    check("stall_no_en_mult", 64'(stall_en), 64'd0);
                    check("stall_busy", 64'(bus.busy), 64'd1);
                end
            end else if (stall_at > 0 && !stall_done && en == stall_at) begin
                stalling = 1;
                stall_done = 1;
                rv = '0;
            end
            if (rst_at >= 0 && res == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                check("rst_busy", 64'(bus.busy), 64'd0);
                check("rst_res_valid", 64'(bus.res_valid), 64'd0);
                check("rst_en_blockread", 64'(bus.EN_blockRead), 64'd0);
                done = 1;
                break;
            end
        end
        check("batch_done", 64'(done), 64'd1);
        if (rst_at < 0) begin
            check("en_mult_count", 64'(en), 64'(DEPTH));
            check("blockread_count", 64'(br), to_mode ? 64'd0 : 64'd1);
            check("res_count", 64'(res), to_mode ? 64'd0 : 64'(DEPTH));
            check("wait_cycles", 64'(wait_n),
                  to_mode ? 64'(TIMEOUT) : 64'(2 + DEPTH));
            check("err", 64'(bus.err), 64'(to_mode));
            check("other_ready", 64'(viol), 64'd0);
        end
        rv = '0;
        spur = 1'b0;
    endtask

    typedef struct {
        logic [NREQ-1:0] v;
        int              g;
    } rr_vec_t;

    rr_vec_t tab [7];

    initial begin
        tab[0] = '{2'b11, 0};
        tab[1] = '{2'b11, 1};
        tab[2] = '{2'b11, 0};
        tab[3] = '{2'b10, 1};
        tab[4] = '{2'b10, 1};
        tab[5] = '{2'b01, 0};
        tab[6] = '{2'b11, 1};

        rv = 2'b11;
        hold_rdy = 1'b0;
        spur = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_en_mult", 64'(bus.EN_mult), 64'd0);
        check("rst_blockread", 64'(bus.EN_blockRead), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_grant_id", 64'(bus.grant_id), 64'd0);
        rv = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(bus.busy), 64'd0);

        for (int i = 0; i < 7; i++)
            run_batch(tab[i].v, tab[i].g, 0, 1'b0, -1, 1'b0);

        run_batch(2'b01, 0, 10, 1'b0, -1, 1'b0);
        run_batch(2'b10, 1, 0, 1'b0, -1, 1'b1);
        run_batch(2'b01, 0, 0, 1'b1, -1, 1'b0);

        repeat (10) @(negedge clk);
        check("err_sticky", 64'(bus.err), 64'd1);
        check("err_idle_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        hold_rdy = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("err_cleared", 64'(bus.err), 64'd0);

        run_batch(2'b10, 1, 0, 1'b0, 30, 1'b0);
        run_batch(2'b11, 0, 0, 1'b0, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
